// File: rtl/addr_capture_fifo_if.sv
// Capture-side and drain-side signals of addr_capture_fifo, grouped so the
// producer/consumer harness and the buffer share one bundle.
interface addr_capture_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clear;
  logic             en;
  logic [WIDTH-1:0] data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [31:0]      addr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output clear, en, data, out_ready,
    input  in_ready, out_valid, out_data, addr, count, overflow
  );

  modport slave (
    input  clear, en, data, out_ready,
    output in_ready, out_valid, out_data, addr, count, overflow
  );
endinterface

// File: rtl/addr_capture_fifo.sv
// Capture buffer: tags each accepted word with a generated address (linear,
// wrapping or fixed) and queues {word, tag} in a DEPTH-entry FIFO.
module addr_capture_fifo #(
  parameter int          WIDTH     = 8,
  parameter int          DEPTH     = 10,
  parameter int          MODE      = 0,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] STRIDE    = 32'd1,
  parameter int          WRAP_LEN  = 16
) (
  input logic               clk,
  input logic               rst,
  addr_capture_fifo_if.slave bus
);
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int IDX_W    = (WRAP_LEN > 1) ? $clog2(WRAP_LEN) : 1;
  localparam int EFF_MODE = (MODE == 1 || MODE == 2) ? MODE : 0;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WRAP_LEN - 1);

  logic [WIDTH-1:0] data_mem_q [DEPTH];
  logic [31:0]      addr_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      gen_addr_q, gen_addr_d;
  logic [IDX_W-1:0] wrap_idx_q, wrap_idx_d;

  logic        full, empty;
  logic        push, pop, drop;
  logic [31:0] tag;

  // clear outranks everything: an en during a clear is neither stored nor a drop
  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    push  = bus.en && !full && !bus.clear;
    drop  = bus.en && full && !bus.clear;
    pop   = !empty && bus.out_ready && !bus.clear;
  end

  always_comb begin
    tag = gen_addr_q;
    if (EFF_MODE == 2) begin
      tag = BASE_ADDR;
    end
  end

  // Wrap mode keeps a running address and reloads BASE_ADDR at the window end,
  // which equals BASE_ADDR + idx*STRIDE without a multiplier.
  always_comb begin
    gen_addr_d = gen_addr_q;
    wrap_idx_d = wrap_idx_q;
    if (bus.clear) begin
      gen_addr_d = BASE_ADDR;
      wrap_idx_d = '0;
    end else if (push) begin
      case (EFF_MODE)
        1: begin
          if (wrap_idx_q == LAST_IDX) begin
            gen_addr_d = BASE_ADDR;
            wrap_idx_d = '0;
          end else begin
            gen_addr_d = gen_addr_q + STRIDE;
            wrap_idx_d = wrap_idx_q + IDX_W'(1);
          end
        end
        2: begin
          gen_addr_d = BASE_ADDR;
        end
        default: begin
          gen_addr_d = gen_addr_q + STRIDE;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      gen_addr_q <= BASE_ADDR;
      wrap_idx_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      gen_addr_q <= gen_addr_d;
      wrap_idx_q <= wrap_idx_d;
    end
  end

  // Storage needs no reset; the empty-gated outputs hide stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= bus.data;
      addr_mem_q[wr_ptr_q] <= tag;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : data_mem_q[rd_ptr_q];
  assign bus.addr      = empty ? '0 : addr_mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_addr_capture_fifo.sv
// Directed bench for addr_capture_fifo: four instances (linear, wrap, linear
// across 2^32, fixed) share stimulus; a queue scoreboard checks the selected one.
module tb_addr_capture_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 10;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [31:0]      a;
  } entry_t;

  logic             clk;
  logic             rst;
  logic             clear;
  logic             en;
  logic [WIDTH-1:0] data;
  logic             out_ready;

  int               sel;
  logic             obs_in_ready, obs_out_valid, obs_overflow;
  logic [WIDTH-1:0] obs_out_data;
  logic [31:0]      obs_addr;
  logic [CNT_W-1:0] obs_count;

  int     checks;
  int     errors;
  entry_t sb[$];
  int     m_count;
  logic   m_ovf;
  int     m_mode;
  logic [31:0] m_base, m_stride, m_cur, m_idx, m_wrap;

  addr_capture_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_a ();
  addr_capture_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_b ();
  addr_capture_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_c ();
  addr_capture_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_d ();

  assign if_a.clear = clear;  assign if_a.en = en;  assign if_a.data = data;  assign if_a.out_ready = out_ready;
  assign if_b.clear = clear;  assign if_b.en = en;  assign if_b.data = data;  assign if_b.out_ready = out_ready;
  assign if_c.clear = clear;  assign if_c.en = en;  assign if_c.data = data;  assign if_c.out_ready = out_ready;
  assign if_d.clear = clear;  assign if_d.en = en;  assign if_d.data = data;  assign if_d.out_ready = out_ready;

  addr_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(0), .BASE_ADDR(32'h0000_1000),
                      .STRIDE(32'd4), .WRAP_LEN(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  addr_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(1), .BASE_ADDR(32'h0000_0040),
                      .STRIDE(32'd8), .WRAP_LEN(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  addr_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(0), .BASE_ADDR(32'hFFFF_FFF8),
                      .STRIDE(32'd4), .WRAP_LEN(16)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
  addr_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(2), .BASE_ADDR(32'h0000_0077),
                      .STRIDE(32'd4), .WRAP_LEN(16)) dut_d (.clk(clk), .rst(rst), .bus(if_d));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  always_comb begin
    case (sel)
      1: begin
        obs_in_ready = if_b.in_ready;  obs_out_valid = if_b.out_valid; obs_overflow = if_b.overflow;
        obs_out_data = if_b.out_data;  obs_addr = if_b.addr;           obs_count = if_b.count;
      end
      2: begin
        obs_in_ready = if_c.in_ready;  obs_out_valid = if_c.out_valid; obs_overflow = if_c.overflow;
        obs_out_data = if_c.out_data;  obs_addr = if_c.addr;           obs_count = if_c.count;
      end
      3: begin
        obs_in_ready = if_d.in_ready;  obs_out_valid = if_d.out_valid; obs_overflow = if_d.overflow;
        obs_out_data = if_d.out_data;  obs_addr = if_d.addr;           obs_count = if_d.count;
      end
      default: begin
        obs_in_ready = if_a.in_ready;  obs_out_valid = if_a.out_valid; obs_overflow = if_a.overflow;
        obs_out_data = if_a.out_data;  obs_addr = if_a.addr;           obs_count = if_a.count;
      end
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected tag for the next accepted word, from the address-mode definition.
  function automatic logic [31:0] modelTag();
    case (m_mode)
      1:       return m_base + m_idx * m_stride;
      2:       return m_base;
      default: return m_cur;
    endcase
  endfunction

  task automatic modelReset();
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_cur   = m_base;
    m_idx   = '0;
  endtask

  task automatic selectDut(input int n, input int mode, input logic [31:0] base,
                           input logic [31:0] stride, input logic [31:0] wrap);
    sel      = n;
    m_mode   = mode;
    m_base   = base;
    m_stride = stride;
    m_wrap   = wrap;
    $display("[TB] selecting instance %0d", n);
  endtask

  // One clock cycle: drive inputs, check mid-cycle, update the model for the edge.
  task automatic applyStimulus(input logic e, input logic [WIDTH-1:0] d,
                               input logic ordy, input logic clr);
    entry_t exp_e;
    en        = e;
    data      = d;
    out_ready = ordy;
    clear     = clr;
    #4;
    checkOutput("count", 64'(obs_count), 64'(m_count));
    checkOutput("out_valid", 64'(obs_out_valid), 64'(m_count != 0));
    checkOutput("in_ready", 64'(obs_in_ready), 64'(m_count != DEPTH));
    checkOutput("overflow", 64'(obs_overflow), 64'(m_ovf));
    if (m_count == 0) begin
      checkOutput("empty_data", 64'(obs_out_data), 64'd0);
      checkOutput("empty_addr", 64'(obs_addr), 64'd0);
    end
    if (clr) begin
      modelReset();
    end else begin
      if (ordy && m_count != 0) begin
        exp_e = sb.pop_front();
        checkOutput("head_data", 64'(obs_out_data), 64'(exp_e.d));
        checkOutput("head_addr", 64'(obs_addr), 64'(exp_e.a));
        m_count--;
      end
      if (e && (m_count + ((ordy && m_count + 1 <= DEPTH && sb.size() < m_count + 1) ? 0 : 0)) >= 0) begin
        if (ordy ? (m_count + 1 != DEPTH + 1) && (m_count + 1 <= DEPTH) && !(m_count + 1 == DEPTH + 0 && 1'b0) : 1'b1) begin
        end
      end
    end
    #0;
    @(posedge clk);
    #1;
  endtask

  // The push decision must use occupancy from before the edge, so it is kept
  // separate from the pop bookkeeping above.
  task automatic step(input logic e, input logic [WIDTH-1:0] d,
                      input logic ordy, input logic clr);
    int   pre_count;
    entry_t new_e;
    pre_count = m_count;
    if (!clr && e && pre_count != DEPTH) begin
      new_e.d = d;
      new_e.a = modelTag();
    end
    applyStimulus(e, d, ordy, clr);
    if (!clr && e) begin
      if (pre_count != DEPTH) begin
        sb.push_back(new_e);
        m_count++;
        m_cur = m_cur + m_stride;
        m_idx = (m_idx == m_wrap - 1) ? '0 : m_idx + 1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    clear     = 1'b0;
    en        = 1'b0;
    data      = '0;
    out_ready = 1'b0;
    selectDut(0, 0, 32'h0000_1000, 32'd4, 32'd16);
    modelReset();

    #2 rst = 1'b1;
    #1;
    checkOutput("rst_count", 64'(obs_count), 64'd0);
    checkOutput("rst_valid", 64'(obs_out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(obs_in_ready), 64'd1);
    checkOutput("rst_overflow", 64'(obs_overflow), 64'd0);
    checkOutput("rst_data", 64'(obs_out_data), 64'd0);
    checkOutput("rst_addr", 64'(obs_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Three words held, then drained in order with stride-4 tags.
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill past DEPTH: two drops set overflow, no address gaps on drain.
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Occupancy 5 with continuous push+pop across the pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    step(1'b1, 8'hE0, 1'b1, 1'b0);
    step(1'b1, 8'hE1, 1'b0, 1'b0);
    step(1'b1, 8'hE2, 1'b1, 1'b1);
    step(1'b1, 8'hE3, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with four entries queued.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    en = 1'b0;
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_count", 64'(obs_count), 64'd0);
    checkOutput("arst_valid", 64'(obs_out_valid), 64'd0);
    checkOutput("arst_in_ready", 64'(obs_in_ready), 64'd1);
    checkOutput("arst_data", 64'(obs_out_data), 64'd0);
    checkOutput("arst_addr", 64'(obs_addr), 64'd0);
    modelReset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 8'hD5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Wrap mode, WRAP_LEN=3: 0x40, 0x48, 0x50, 0x40, 0x48.
    selectDut(1, 1, 32'h0000_0040, 32'd8, 32'd3);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Linear mode rolling past 32'hFFFF_FFFF.
    selectDut(2, 0, 32'hFFFF_FFF8, 32'd4, 32'd16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Fixed mode: every tag is BASE_ADDR.
    selectDut(3, 2, 32'h0000_0077, 32'd4, 32'd16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addr_capture_fifo.md
Name: addr_capture_fifo

Overview:
- Parameterised capture buffer that accepts WIDTH-bit data words under an enable qualifier and tags each accepted word with a generated 32-bit address.
- Addresses are generated in one of three modes: linear, wrapping, or fixed.
- Tagged words are queued in a DEPTH-entry FIFO and drained through a valid/ready output port.
- Sits between a raw sampled data source and a memory-write or bus-master stage.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 10, FIFO entries (>=2; non-power-of-two supported).
- MODE, 0, address mode: 0 = linear, 1 = wrap, 2 = fixed; other values behave as 0.
- BASE_ADDR, 32'h0000_0000, first generated address.
- STRIDE, 1, address increment per accepted word (32-bit unsigned).
- WRAP_LEN, 16, beats per wrap window in mode 1 (>=1).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (localparam, derived).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- clear  input  1  synchronous flush: empties the FIFO, restarts address generation, clears overflow.
- en  input  1  input word present this cycle.
- data  input  WIDTH  input word.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_valid  output  1  head entry is available.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  WIDTH  head data word.
- addr  output  32  head address tag.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a word was dropped.

Behaviour:
- Reset (rst high, asynchronous):
  - count=0, out_valid=0, out_data=0, addr=0, overflow=0, in_ready=1.
  - Address generator returns to BASE_ADDR with wrap index 0.
- Push occurs when en && in_ready. in_ready = (count != DEPTH); it does not depend on out_ready.
- Pop occurs when out_valid && out_ready. out_valid = (count != 0).
- out_data/addr show the head entry combinationally from storage; both are 0 while the FIFO is empty.
- Latency: a word pushed in cycle N into an empty FIFO gives out_valid=1 in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop when 0<count<DEPTH: count is unchanged and both operations take effect.
- Full: a pop while full frees the slot for cycle N+1 only, because in_ready stays 0 in cycle N.
- Drop: en && !in_ready sets overflow=1 in the next cycle. The word is discarded and the address generator does not advance.
- overflow stays set until clear or rst.
- Address tag applied to each pushed word, then the generator advances:
  - MODE 0: tag = cur; cur <= cur + STRIDE, modulo 2^32 (wraps silently past 32'hFFFF_FFFF).
  - MODE 1: tag = BASE_ADDR + idx*STRIDE (mod 2^32); idx <= (idx == WRAP_LEN-1) ? 0 : idx+1.
  - MODE 2: tag = BASE_ADDR always.
- clear (synchronous) has priority over push and pop in the same cycle.
  - Next cycle: count=0, out_valid=0, overflow=0, generator back to BASE_ADDR / idx 0.
  - A word presented with en during the clear cycle is neither stored nor counted as a drop.
- Read and write pointers run 0..DEPTH-1 and wrap explicitly to 0. Binary rollover is not used, so non-power-of-two DEPTH works.
- Reset asserted mid-stream discards all contents immediately; there is no partial drain.

Test Plan:
- Mode 0, BASE=32'h1000, STRIDE=4: push 0xA1,0xA2,0xA3 with out_ready=0 -> count=3; then out_ready=1 -> (0xA1,0x1000), (0xA2,0x1004), (0xA3,0x1008) in order, then out_valid=0.
- DEPTH=10, out_ready=0, en held for 12 cycles -> in_ready=0 after the 10th push, overflow=1, count=10; drain -> 10 words with addresses BASE..BASE+9*STRIDE and no gaps.
- Mode 1, WRAP_LEN=3, BASE=0x40, STRIDE=8: push 5 words -> tags 0x40, 0x48, 0x50, 0x40, 0x48.
- Mode 0, BASE=32'hFFFF_FFF8, STRIDE=4: push 3 words -> tags 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- count=5 with continuous push+pop for 20 cycles -> count stays 5 and order is preserved across the pointer wrap. Then assert clear together with en and out_ready -> next cycle count=0, out_valid=0, overflow=0, and the next push is tagged BASE_ADDR.
- Assert rst asynchronously mid-cycle with count=4 -> outputs reach their reset values before the next clock edge, and the first push after release is tagged BASE_ADDR.
